// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: fixed-latency word RAM access with error reporting and counters
module dmem_ctrl #(
  parameter int DEPTH_POW2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_rd_data_o,
  output logic        dmem_done_o,
  output logic        dmem_err_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);

  localparam int Words = 2 ** DEPTH_POW2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_POW2-1:0]   idx_q;
  logic [31:0]             data_q;
  logic                    wr_q;
  logic                    err_q;

  logic                    req;
  logic                    req_err;
  logic                    commit;
  logic [DEPTH_POW2-1:0]   c_idx;
  logic [31:0]             c_data;
  logic                    c_wr;
  logic                    c_err;

  logic [31:0]             mem [Words];

  assign req     = dmem_read_i | dmem_write_i;
  assign req_err = (dmem_read_i & dmem_write_i)
                 | (|dmem_addr_i[1:0])
                 | (|dmem_addr_i[31:DEPTH_POW2+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the commit edge is also the sample edge, so use the live inputs there.
  assign commit = (state_d == DONE);
  assign c_idx  = (state_q == IDLE) ? dmem_addr_i[DEPTH_POW2+1:2] : idx_q;
  assign c_data = (state_q == IDLE) ? dmem_data_i : data_q;
  assign c_wr   = (state_q == IDLE) ? dmem_write_i : wr_q;
  assign c_err  = (state_q == IDLE) ? req_err : err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= 32'h0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        idx_q  <= dmem_addr_i[DEPTH_POW2+1:2];
        data_q <= dmem_data_i;
        wr_q   <= dmem_write_i;
        err_q  <= req_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dmem_done_o    <= 1'b0;
      dmem_err_o     <= 1'b0;
      dmem_rd_data_o <= 32'h0;
      rd_count_o     <= 16'h0;
      wr_count_o     <= 16'h0;
    end else begin
      dmem_done_o <= commit;
      dmem_err_o  <= commit & c_err;
      if (commit && !c_err) begin
        if (c_wr) begin
          if (wr_count_o != 16'hFFFF) wr_count_o <= wr_count_o + 16'd1;
        end else begin
          dmem_rd_data_o <= mem[c_idx];
          if (rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
        end
      end
    end
  end

  // RAM contents survive reset; an aborted request never reaches commit.
  always_ff @(posedge clk_i) begin
    if (commit && !c_err && c_wr) mem[c_idx] <= c_data;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - randomized self-checking bench for dmem_ctrl at LATENCY 2 and 1
module tb_dmem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [31:0] addr_r [2];
  logic [31:0] data_r [2];
  logic [31:0] rdata_w[2];
  logic        done_w [2];
  logic        err_w  [2];
  logic [15:0] rc_w   [2];
  logic [15:0] wc_w   [2];

  int n_tests;
  int n_fail;

  logic [31:0] mem_m   [2][1024];
  bit          vld_m   [2][1024];
  logic [31:0] rdata_m [2];
  int          rcnt_m  [2];
  int          wcnt_m  [2];

  dmem_ctrl #(.DEPTH_POW2(10), .LATENCY(2)) dut2 (
    .clk_i(clk), .reset_ni(reset_n),
    .dmem_read_i(rd_r[0]), .dmem_write_i(wr_r[0]),
    .dmem_addr_i(addr_r[0]), .dmem_data_i(data_r[0]),
    .dmem_rd_data_o(rdata_w[0]), .dmem_done_o(done_w[0]), .dmem_err_o(err_w[0]),
    .rd_count_o(rc_w[0]), .wr_count_o(wc_w[0])
  );

  dmem_ctrl #(.DEPTH_POW2(10), .LATENCY(1)) dut1 (
    .clk_i(clk), .reset_ni(reset_n),
    .dmem_read_i(rd_r[1]), .dmem_write_i(wr_r[1]),
    .dmem_addr_i(addr_r[1]), .dmem_data_i(data_r[1]),
    .dmem_rd_data_o(rdata_w[1]), .dmem_done_o(done_w[1]), .dmem_err_o(err_w[1]),
    .rd_count_o(rc_w[1]), .wr_count_o(wc_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int d, input string tag);
    check($sformatf("%s_rdata_d%0d", tag, d), rdata_w[d], rdata_m[d]);
    check($sformatf("%s_rcnt_d%0d", tag, d), 32'(rc_w[d]), 32'(rcnt_m[d]));
    check($sformatf("%s_wcnt_d%0d", tag, d), 32'(wc_w[d]), 32'(wcnt_m[d]));
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_req(input int d, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] dat, input bit scr, input bit hold);
    int lat;
    bit err;
    int idx;
    lat = (d == 0) ? 2 : 1;
    err = (rd && wr) || (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
    idx = int'(a[11:2]);
    rd_r[d] = rd; wr_r[d] = wr; addr_r[d] = a; data_r[d] = dat;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check($sformatf("early_done_d%0d_k%0d", d, k), 32'(done_w[d]), 32'd0);
      @(posedge clk); #1;
      if (scr && k < lat - 1) begin
        addr_r[d] = 32'h10;
        data_r[d] = ~dat;
      end
    end
    if (!err) begin
      if (wr) begin
        mem_m[d][idx] = dat;
        vld_m[d][idx] = 1'b1;
        if (wcnt_m[d] < 16'hFFFF) wcnt_m[d]++;
      end else begin
        rdata_m[d] = mem_m[d][idx];
        if (rcnt_m[d] < 16'hFFFF) rcnt_m[d]++;
      end
    end
    @(negedge clk);
    check($sformatf("done_d%0d_a%h", d, a), 32'(done_w[d]), 32'd1);
    check($sformatf("err_d%0d_a%h", d, a), 32'(err_w[d]), 32'(err));
    check_outs(d, "op");
    if (!hold) begin
      rd_r[d] = 1'b0;
      wr_r[d] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int d = 0; d < 2; d++) begin
      rd_r[d] = 0; wr_r[d] = 0; addr_r[d] = 0; data_r[d] = 0;
      rdata_m[d] = 0; rcnt_m[d] = 0; wcnt_m[d] = 0;
      for (int i = 0; i < 1024; i++) begin
        vld_m[d][i] = 0;
        mem_m[d][i] = 0;
      end
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_done_d%0d", d), 32'(done_w[d]), 32'd0);
      check($sformatf("rst_err_d%0d", d), 32'(err_w[d]), 32'd0);
      check_outs(d, "rst");
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
    run_req(0, 1, 0, 32'h10, 32'h0, 0, 0);
    run_req(0, 0, 1, 32'h20, 32'h1, 1, 0);
    run_req(0, 1, 0, 32'h20, 32'h0, 0, 0);
    run_req(0, 1, 0, 32'h10, 32'h0, 0, 0);

    run_req(0, 1, 0, 32'h3, 32'h0, 0, 0);
    run_req(0, 1, 0, 32'h1000, 32'h0, 0, 0);
    run_req(0, 1, 1, 32'h10, 32'h77, 0, 0);

    run_req(0, 1, 0, 32'h20, 32'h0, 0, 1);
    run_req(0, 1, 0, 32'h20, 32'h0, 0, 0);

    run_req(0, 0, 1, 32'h40, 32'h5, 0, 0);
    rd_r[0] = 0; wr_r[0] = 1; addr_r[0] = 32'h40; data_r[0] = 32'h9;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      rdata_m[d] = 0; rcnt_m[d] = 0; wcnt_m[d] = 0;
    end
    check("async_rst_done", 32'(done_w[0]), 32'd0);
    check_outs(0, "async_rst");
    @(negedge clk);
    check("rst_hold_done", 32'(done_w[0]), 32'd0);
    wr_r[0] = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_req(0, 1, 0, 32'h40, 32'h0, 0, 0);

    run_req(1, 0, 1, 32'h0, 32'hA5A5_0001, 0, 0);
    run_req(1, 0, 1, 32'h4, 32'h5A5A_0002, 0, 0);
    run_req(1, 1, 0, 32'h0, 32'h0, 0, 0);
    run_req(1, 1, 0, 32'h4, 32'h0, 0, 0);
    run_req(1, 1, 0, 32'h2, 32'h0, 0, 0);

    force dut1.wr_count_o = 16'hFFFE;
    #1;
    release dut1.wr_count_o;
    #1;
    wcnt_m[1] = 16'hFFFE;
    check("forced_wcnt", 32'(wc_w[1]), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) run_req(1, 0, 1, 32'(8 + 4 * i), $urandom, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int d, r;
      logic [31:0] a;
      d = i % 2;
      r = $urandom_range(0, 9);
      a = {20'h0, 10'($urandom_range(0, 31)), 2'b00};
      if (r < 4 || (r < 7 && !vld_m[d][a[11:2]])) run_req(d, 0, 1, a, $urandom, 0, 0);
      else if (r < 7) run_req(d, 1, 0, a, 32'h0, 0, 0);
      else if (r == 7) run_req(d, 1, 0, a | 32'($urandom_range(1, 3)), 32'h0, 0, 0);
      else if (r == 8) run_req(d, 0, 1, a | (32'h1 << $urandom_range(12, 31)), $urandom, 0, 0);
      else run_req(d, 1, 1, a, $urandom, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller on the far side of the data memory interface driven by the load/store path's dmem read/write unit.
- Accepts one level-held read or write request at a time and performs it on an internal word-addressed RAM after a fixed, parameterised latency.
- Pulses done for one cycle and reports errors for illegal requests.
- Keeps saturating access counters for performance debug.

Parameters:
- DEPTH_POW2, 10: RAM holds 2**DEPTH_POW2 32-bit words.
- LATENCY, 2: cycles from request sample to done pulse. Legal range 1..15.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- dmem_read_i  in  1  read request, held until done.
- dmem_write_i  in  1  write request, held until done.
- dmem_addr_i  in  32  byte address.
- dmem_data_i  in  32  store data.
- dmem_rd_data_o  out  32  load data, valid in the done cycle of a read and held afterwards.
- dmem_done_o  out  1  one-cycle completion pulse.
- dmem_err_o  out  1  high with done when the request was illegal.
- rd_count_o  out  16  completed legal reads, saturating.
- wr_count_o  out  16  completed legal writes, saturating.

Behaviour:
- Single clock. Reset is asynchronous and active-low: all state clears immediately on reset_ni low.
- Reset values: state=IDLE, dmem_rd_data_o=0, dmem_done_o=0, dmem_err_o=0, rd_count_o=0, wr_count_o=0, wait counter=0.
- RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on a clock edge with dmem_read_i or dmem_write_i high:
  - capture addr, data, op and error into registers;
  - go to WAIT with counter=LATENCY-1, or straight to DONE if LATENCY=1.
  - Inputs are not looked at again until the next IDLE.
- WAIT: decrement the counter each cycle; go to DONE on the edge where the counter is 1.
- Latency: a request first seen in cycle T gives dmem_done_o=1 in cycle T+LATENCY, for exactly one cycle.
- DONE: dmem_done_o=1 and dmem_err_o=captured error. Request inputs are ignored. Next state is always IDLE.
  - A request still asserted in the cycle after DONE is a new request. The requester must drop the request in the done cycle.
- Access commit happens on the edge entering DONE:
  - legal write stores the captured data at word index addr[DEPTH_POW2+1:2];
  - legal read loads dmem_rd_data_o from that index.
- dmem_rd_data_o changes only on a read commit. Writes and errors leave it unchanged.
- Error conditions:
  - read and write both high at sample;
  - addr[1:0] != 0;
  - any addr[31:DEPTH_POW2+2] bit set.
- On error: no RAM access, dmem_rd_data_o unchanged, counters unchanged. Error requests still take the full LATENCY cycles.
- Counters increment by 1 on each legal read/write commit and saturate at 16'hFFFF.
- Reset mid-operation: any captured, uncommitted write is dropped, RAM is unchanged, and no done pulse is produced. After reset release the FSM starts in IDLE.
- The registered-output contract is the same for all LATENCY values.

Test Plan:
- LATENCY=2: write addr 0x10, data 0xDEADBEEF at T0, dropped after done.
  -> done=1 only in T2, err=0, wr_count=1. Then read 0x10 -> rd_data=0xDEADBEEF in the done cycle, rd_count=1.
- Change addr/data during WAIT of a write to 0x20 (data 0x1).
  -> only word 0x20 written with 0x1. Read back 0x20=0x1; the other address is untouched.
- Requests: read addr 0x3, then addr 0x1000 (DEPTH_POW2=10), then read+write together.
  -> each gives done with err=1 at T+LATENCY. rd_data and counters are unchanged.
- Requester keeps read held one extra cycle past done.
  -> second done exactly LATENCY+1 cycles after the first, rd_count=2.
- Assert reset_ni low mid-WAIT of a write to 0x40 (old value 0x5).
  -> done stays 0, outputs are 0 immediately, and a later read of 0x40 returns 0x5.
- LATENCY=1, back-to-back writes to 0x0 and 0x4 with the request dropped each done cycle.
  -> done every 2nd cycle. Force the write counter to 16'hFFFE, then do 3 writes -> wr_count=16'hFFFF.
